// File: rtl/fifo_wr_ctrl_if.sv
// Bundle of write-side FIFO signals shared by the producer, the read side and
// the write controller. The optional overflow counter only appears in the
// bundle when FIFO_WR_OVF_CNT_EN is defined.
// master : environment side (producer request, read pointer, overflow clear)
// slave  : fifo_wr_ctrl side (strobe, address, pointer and status outputs)
interface fifo_wr_ctrl_if #(
   parameter int AW = 8
);

   logic          en;
   logic [AW:0]   rd_ptr;
   logic          ovf_clr;
   logic          push;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_ptr;
   logic          full;
   logic          almost_full;
   logic [AW:0]   level;
   logic [1:0]    state;
   logic          overflow;
`ifdef FIFO_WR_OVF_CNT_EN
   logic [7:0]    ovf_cnt;
`endif

`ifdef FIFO_WR_OVF_CNT_EN
   modport master (
      output en, rd_ptr, ovf_clr,
      input  push, wr_addr, wr_ptr, full, almost_full, level, state, overflow,
             ovf_cnt
   );

   modport slave (
      input  en, rd_ptr, ovf_clr,
      output push, wr_addr, wr_ptr, full, almost_full, level, state, overflow,
             ovf_cnt
   );
`else
   modport master (
      output en, rd_ptr, ovf_clr,
      input  push, wr_addr, wr_ptr, full, almost_full, level, state, overflow
   );

   modport slave (
      input  en, rd_ptr, ovf_clr,
      output push, wr_addr, wr_ptr, full, almost_full, level, state, overflow
   );
`endif

endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the synchronous FIFO.
// Accepts producer write requests with zero latency, generates the memory
// write strobe/address, keeps the extended (wrap-bit) write pointer and
// derives full, almost-full and fill level against the read-side pointer.
// A sticky overflow flag records every request rejected because of full.
// Optional feature macro: FIFO_WR_OVF_CNT_EN adds an 8-bit saturating count
// of rejected write cycles (bus.ovf_cnt).
module fifo_wr_ctrl #(
   parameter int AW           = 8,
   parameter int AFULL_THRESH = (2 ** AW) - 2
) (
   input  logic           clk,
   input  logic           arst,
   fifo_wr_ctrl_if.slave  bus
);

   // Outcome of the previous cycle; encoding is visible on the state port.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FULL = 2'd1,
      PUSH = 2'd2
   } state_t;

   localparam logic [AW:0] AFULL_LVL = (AW + 1)'(AFULL_THRESH);
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q;
   logic [AW:0] wr_ptr_d;
   state_t      state_q;
   state_t      state_d;
   logic        overflow_q;
   logic        overflow_d;
   logic        full_w;
   logic        push_w;
   logic        reject_w;
   logic [AW:0] level_w;

   // Full when the pointers address the same slot but differ in wrap bit;
   // the write is accepted in the same cycle it is requested unless full.
   always_comb begin
      full_w   = (wr_ptr_q[AW] != bus.rd_ptr[AW]) &&
                 (wr_ptr_q[AW-1:0] == bus.rd_ptr[AW-1:0]);
      level_w  = wr_ptr_q - bus.rd_ptr;
      push_w   = bus.en && !full_w;
      reject_w = bus.en && full_w;
   end

   // Pointer advance on an accepted write; natural wrap of the AW+1 bits.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (push_w) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   // Extended write pointer register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Next outcome depends only on this cycle's request, so any stray
   // encoding (including 3) falls back to IDLE after one clock.
   always_comb begin
      state_d = IDLE;
      if (push_w) begin
         state_d = PUSH;
      end else if (reject_w) begin
         state_d = FULL;
      end
   end

   // Outcome state register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sticky overflow: a rejection in the same cycle as a clear still sets it.
   always_comb begin
      overflow_d = overflow_q;
      if (reject_w) begin
         overflow_d = 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

`ifdef FIFO_WR_OVF_CNT_EN
   logic [7:0] ovf_cnt_q;
   logic [7:0] ovf_cnt_d;

   // Saturating rejection count; a clear coinciding with a rejection
   // restarts the count at 1 so that rejection is not lost.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (reject_w) begin
         if (bus.ovf_clr) begin
            ovf_cnt_d = 8'd1;
         end else if (ovf_cnt_q != 8'hFF) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
         end
      end else if (bus.ovf_clr) begin
         ovf_cnt_d = 8'd0;
      end
   end

   // Rejection counter register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ovf_cnt_q <= 8'd0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign bus.ovf_cnt = ovf_cnt_q;
`endif

   assign bus.push        = push_w;
   assign bus.wr_addr     = wr_ptr_q[AW-1:0];
   assign bus.wr_ptr      = wr_ptr_q;
   assign bus.full        = full_w;
   assign bus.almost_full = (level_w >= AFULL_LVL);
   assign bus.level       = level_w;
   assign bus.state       = state_q;
   assign bus.overflow    = overflow_q;

endmodule
